// File: rtl/code_mem_arbiter_pkg.sv
// Shared definitions for the code memory arbiter: grant codes and parameter defaults.
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 12
`endif

package code_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_CORE = 2'd1,
    G_VRD  = 2'd2,
    G_VWR  = 2'd3
  } grant_e;

  localparam int unsigned DEF_CODE_ADDR_WIDTH = `CODE_ADDR_WIDTH;

  localparam int unsigned DEF_MAX_VISOR_BURST = 4;

endpackage

// File: rtl/code_mem_arbiter_if.sv
// Core fetch, visor and code RAM signals seen by the arbiter.
interface code_mem_arbiter_if
  import code_mem_arbiter_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = DEF_CODE_ADDR_WIDTH
) ();

  logic [CODE_ADDR_WIDTH-1:0] core_addr;
  logic [15:0]                core_data;
  logic                       core_ready;

  logic                       visor_req;
  logic                       visor_we;
  logic [CODE_ADDR_WIDTH-1:0] visor_addr;
  logic [15:0]                visor_wdata;
  logic                       visor_lock;
  logic                       visor_ack;
  logic                       visor_rvalid;
  logic [15:0]                visor_rdata;

  logic [CODE_ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]                mem_wdata;
  logic                       mem_we;
  logic [15:0]                mem_rdata;

  logic [1:0]                 arb_state;

  modport slave (
    input  core_addr, visor_req, visor_we, visor_addr, visor_wdata, visor_lock, mem_rdata,
    output core_data, core_ready, visor_ack, visor_rvalid, visor_rdata,
           mem_addr, mem_wdata, mem_we, arb_state
  );

  modport master (
    output core_addr, visor_req, visor_we, visor_addr, visor_wdata, visor_lock, mem_rdata,
    input  core_data, core_ready, visor_ack, visor_rvalid, visor_rdata,
           mem_addr, mem_wdata, mem_we, arb_state
  );

endinterface

// File: rtl/code_mem_arbiter.sv
// Shares the single-port code RAM between core instruction fetch and the visor port.
module code_mem_arbiter
  import code_mem_arbiter_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = DEF_CODE_ADDR_WIDTH,
  parameter int unsigned MAX_VISOR_BURST = DEF_MAX_VISOR_BURST
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  code_mem_arbiter_if.slave bus
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_VISOR_BURST);

  grant_e      grant_q, grant_d;
  logic [3:0]  burst_q, burst_d;
  logic [15:0] core_hold_q, visor_hold_q;
  logic        grant_visor, grant_core;

  always_comb begin
    grant_visor = bus.visor_req && (bus.visor_lock || (burst_q < BURST_LIMIT));
    grant_core  = !grant_visor && !bus.visor_lock;

    grant_d = G_IDLE;
    if (grant_core) begin
      grant_d = G_CORE;
    end else if (grant_visor) begin
      grant_d = bus.visor_we ? G_VWR : G_VRD;
    end

    // Streak only grows on unlocked visor grants; anything else restarts it.
    burst_d = '0;
    if (grant_visor && !bus.visor_lock) begin
      burst_d = burst_q + 4'd1;
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      grant_q      <= G_IDLE;
      burst_q      <= '0;
      core_hold_q  <= '0;
      visor_hold_q <= '0;
    end else begin
      grant_q <= grant_d;
      burst_q <= burst_d;
      if (grant_q == G_CORE) begin
        core_hold_q <= bus.mem_rdata;
      end
      if (grant_q == G_VRD) begin
        visor_hold_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = grant_visor ? bus.visor_addr : bus.core_addr;
  assign bus.mem_wdata = bus.visor_wdata;
  assign bus.mem_we    = grant_visor && bus.visor_we && sysreset_n;
  assign bus.visor_ack = grant_visor;

  // Returned data is forwarded straight from the RAM in the return cycle and held afterwards.
  assign bus.core_ready   = (grant_q == G_CORE);
  assign bus.core_data    = (grant_q == G_CORE) ? bus.mem_rdata : core_hold_q;
  assign bus.visor_rvalid = (grant_q == G_VRD);
  assign bus.visor_rdata  = (grant_q == G_VRD) ? bus.mem_rdata : visor_hold_q;
  assign bus.arb_state    = grant_q;

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Self-checking bench for code_mem_arbiter: randomized visor/core traffic against a behavioural model.
module tb_code_mem_arbiter;

  localparam int AW   = 12;
  localparam int MAXB = 4;

  logic sysclk;
  logic sysreset_n;

  code_mem_arbiter_if #(.CODE_ADDR_WIDTH(AW)) bus ();

  code_mem_arbiter #(.CODE_ADDR_WIDTH(AW), .MAX_VISOR_BURST(MAXB)) dut (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .bus        (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Code RAM: one-cycle synchronous read.
  logic [15:0] ram [0:4095];
  always @(posedge sysclk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Core model: re-presents an unserved address, advances when the previous fetch returned.
  logic [AW-1:0] prev_addr;
  always @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) prev_addr <= '0;
    else             prev_addr <= bus.core_addr;
  end
  assign bus.core_addr = prev_addr + AW'(bus.core_ready);

  // Reference model state
  logic [15:0] shadow [0:4095];
  int          streak;
  bit          e_ack, e_we, e_ready, e_rvalid;
  logic [AW-1:0] e_maddr, ret_addr;
  logic [15:0] e_cdata, e_rdata;
  logic [1:0]  e_arb;
  bit          o_ack, o_we, o_ready, o_rvalid;
  logic [AW-1:0] o_maddr;
  logic [15:0] o_cdata, o_rdata;
  logic [1:0]  o_arb;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    streak = 0;
    e_ready = 0; e_rvalid = 0; e_cdata = '0; e_rdata = '0; e_arb = 2'd0;
    e_ack = 0; e_we = 0; ret_addr = '0;
  endtask

  // Advance one clock from a negedge to the next negedge, updating the model.
  task automatic step();
    bit gv, gc, we;
    logic [AW-1:0] ca, va;
    logic [15:0] wd;
    #1;
    we = bus.visor_we; va = bus.visor_addr; wd = bus.visor_wdata; ca = bus.core_addr;
    gv = bus.visor_req && (bus.visor_lock || streak < MAXB);
    gc = !gv && !bus.visor_lock;
    e_ack = gv; e_we = gv && we; e_maddr = gv ? va : ca;
    o_ack = bus.visor_ack; o_we = bus.mem_we; o_maddr = bus.mem_addr;
    @(posedge sysclk);
    e_ready  = gc;
    e_rvalid = gv && !we;
    if (gc) begin e_cdata = shadow[ca]; ret_addr = ca; end
    if (gv && !we) e_rdata = shadow[va];
    if (gv && we) shadow[va] = wd;
    e_arb  = gc ? 2'd1 : (gv ? (we ? 2'd3 : 2'd2) : 2'd0);
    streak = (gv && !bus.visor_lock) ? streak + 1 : 0;
    @(negedge sysclk);
    o_ready = bus.core_ready; o_cdata = bus.core_data;
    o_rvalid = bus.visor_rvalid; o_rdata = bus.visor_rdata; o_arb = bus.arb_state;
  endtask

  task automatic idle_visor();
    bus.visor_req = 0; bus.visor_we = 0; bus.visor_lock = 0;
    bus.visor_addr = '0; bus.visor_wdata = '0;
  endtask

  task automatic test_reset();
    idle_visor();
    sysreset_n = 0;
    repeat (2) @(negedge sysclk);
    total++;
    if ({bus.core_ready, bus.core_data, bus.visor_rvalid, bus.visor_rdata, bus.arb_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b cdata=%h rv=%b rdata=%h arb=%0d want all zero",
               bus.core_ready, bus.core_data, bus.visor_rvalid, bus.visor_rdata, bus.arb_state);
    end
    sysreset_n = 1;
    model_reset();
    total++;
    if (bus.core_ready !== 1'b0) begin bad++; $display("FAIL reset_cycle0_ready got %b want 0", bus.core_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (o_ready !== 1'b1 || o_cdata !== 16'(16'h1000 + k)) begin
        bad++;
        $display("FAIL reset_fetch%0d got rdy=%b data=%h want rdy=1 data=%h", k, o_ready, o_cdata, 16'(16'h1000 + k));
      end
    end
  endtask

  task automatic test_visor_write();
    logic [AW-1:0] held;
    bit found;
    held = bus.core_addr;
    bus.visor_req = 1; bus.visor_we = 1; bus.visor_addr = 12'h005; bus.visor_wdata = 16'hBEEF;
    step();
    total++;
    if (o_ack !== 1'b1 || o_we !== 1'b1 || o_maddr !== 12'h005) begin
      bad++;
      $display("FAIL vwrite_accept got ack=%b we=%b addr=%h want ack=1 we=1 addr=005", o_ack, o_we, o_maddr);
    end
    total++;
    if (o_ready !== 1'b0 || bus.core_addr !== held) begin
      bad++;
      $display("FAIL vwrite_core_hold got rdy=%b addr=%h want rdy=0 addr=%h", o_ready, bus.core_addr, held);
    end
    idle_visor();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      total++;
      if ({o_ready, o_cdata, o_rvalid, o_arb} !== {e_ready, e_cdata, e_rvalid, e_arb}) begin
        bad++;
        $display("FAIL vwrite_model c%0d got rdy=%b cd=%h rv=%b arb=%0d want %b %h %b %0d",
                 c, o_ready, o_cdata, o_rvalid, o_arb, e_ready, e_cdata, e_rvalid, e_arb);
      end
      if (e_ready && ret_addr == 12'h005) begin
        found = 1;
        total++;
        if (o_cdata !== 16'hBEEF) begin bad++; $display("FAIL vwrite_readback got %h want beef", o_cdata); end
      end
    end
    if (!found) begin total++; bad++; $display("FAIL vwrite_readback timeout: core never fetched 005"); end
  endtask

  task automatic test_burst_reads();
    int nrv, nrdy;
    nrv = 0; nrdy = 0;
    bus.visor_req = 1; bus.visor_we = 0; bus.visor_addr = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 25; i++) begin
      step();
      total++;
      if (o_ack !== ((i % 5) != 4) || {o_ready, o_cdata, o_rvalid, o_rdata, o_arb} !== {e_ready, e_cdata, e_rvalid, e_rdata, e_arb}) begin
        bad++;
        $display("FAIL burst c%0d got ack=%b rdy=%b cd=%h rv=%b rd=%h arb=%0d want ack=%b %b %h %b %h %0d",
                 i, o_ack, o_ready, o_cdata, o_rvalid, o_rdata, o_arb, (i % 5) != 4, e_ready, e_cdata, e_rvalid, e_rdata, e_arb);
      end
      nrv += int'(o_rvalid); nrdy += int'(o_ready);
      if (o_ack) bus.visor_addr = 12'($urandom_range(0, 4095));
    end
    total++;
    if (nrv != 20 || nrdy != 5) begin bad++; $display("FAIL burst_counts got rvalid=%0d ready=%0d want 20 5", nrv, nrdy); end
    idle_visor();
  endtask

  task automatic test_lock_idle();
    bus.visor_lock = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (o_ack !== 1'b0 || o_we !== 1'b0 || o_ready !== 1'b0 || o_arb !== 2'd0) begin
        bad++;
        $display("FAIL lock_idle c%0d got ack=%b we=%b rdy=%b arb=%0d want 0 0 0 0", i, o_ack, o_we, o_ready, o_arb);
      end
    end
    bus.visor_lock = 0;
    step();
    total++;
    if (o_ready !== 1'b1 || o_cdata !== e_cdata) begin
      bad++;
      $display("FAIL lock_release got rdy=%b cd=%h want rdy=1 cd=%h", o_ready, o_cdata, e_cdata);
    end
  endtask

  task automatic test_lock_writes();
    logic [AW-1:0] addrs [0:3];
    bus.visor_lock = 1; bus.visor_req = 1; bus.visor_we = 1;
    for (int i = 0; i < 20; i++) begin
      bus.visor_addr = 12'($urandom_range(0, 4095)); bus.visor_wdata = 16'($urandom);
      if (i < 4) addrs[i] = bus.visor_addr;
      step();
      total++;
      if (o_ack !== 1'b1 || o_we !== 1'b1 || o_maddr !== bus.visor_addr || o_ready !== 1'b0 || o_arb !== 2'd3) begin
        bad++;
        $display("FAIL lock_write c%0d got ack=%b we=%b ma=%h rdy=%b arb=%0d want 1 1 %h 0 3",
                 i, o_ack, o_we, o_maddr, o_ready, o_arb, bus.visor_addr);
      end
    end
    // A cleared streak must allow a full burst of reads before the core is forced in.
    bus.visor_lock = 0; bus.visor_we = 0;
    for (int i = 0; i < 5; i++) begin
      bus.visor_addr = addrs[i % 4];
      step();
      total++;
      if (o_ack !== (i != 4) || {o_ready, o_rvalid, o_rdata} !== {e_ready, e_rvalid, e_rdata}) begin
        bad++;
        $display("FAIL lock_burst c%0d got ack=%b rdy=%b rv=%b rd=%h want ack=%b %b %b %h",
                 i, o_ack, o_ready, o_rvalid, o_rdata, i != 4, e_ready, e_rvalid, e_rdata);
      end
    end
    idle_visor();
  endtask

  task automatic test_reset_inflight();
    bus.visor_req = 1; bus.visor_we = 0; bus.visor_addr = 12'h123;
    #1;
    total++;
    if (bus.visor_ack !== 1'b1) begin bad++; $display("FAIL rst_inflight_ack got %b want 1", bus.visor_ack); end
    #2;
    sysreset_n = 0;
    bus.visor_we = 1;
    #1;
    total++;
    if (bus.visor_rvalid !== 1'b0 || bus.core_ready !== 1'b0 || bus.arb_state !== 2'd0 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got rv=%b rdy=%b arb=%0d we=%b want 0 0 0 0",
               bus.visor_rvalid, bus.core_ready, bus.arb_state, bus.mem_we);
    end
    @(negedge sysclk);
    total++;
    if (bus.visor_rvalid !== 1'b0 || bus.visor_rdata !== 16'h0 || bus.core_data !== 16'h0) begin
      bad++;
      $display("FAIL rst_discard got rv=%b rd=%h cd=%h want 0 0 0", bus.visor_rvalid, bus.visor_rdata, bus.core_data);
    end
    idle_visor();
    sysreset_n = 1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (o_ready !== 1'b1 || o_cdata !== shadow[k]) begin
        bad++;
        $display("FAIL rst_resume%0d got rdy=%b cd=%h want 1 %h", k, o_ready, o_cdata, shadow[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (!(bus.visor_req && !o_ack)) begin
        bus.visor_req   = ($urandom_range(0, 2) != 0);
        bus.visor_we    = $urandom_range(0, 1) == 1;
        bus.visor_addr  = ($urandom_range(0, 1) == 1) ? AW'(prev_addr + AW'($urandom_range(0, 3)))
                                                      : AW'($urandom_range(0, 4095));
        bus.visor_wdata = 16'($urandom);
      end
      if (c % 20 == 0) bus.visor_lock = ($urandom_range(0, 3) == 0);
      step();
      total++;
      if ({o_ack, o_we, o_maddr, o_ready, o_cdata, o_rvalid, o_rdata, o_arb} !==
          {e_ack, e_we, e_maddr, e_ready, e_cdata, e_rvalid, e_rdata, e_arb}) begin
        bad++;
        $display("FAIL random c%0d got ack=%b we=%b ma=%h rdy=%b cd=%h rv=%b rd=%h arb=%0d want %b %b %h %b %h %b %h %0d",
                 c, o_ack, o_we, o_maddr, o_ready, o_cdata, o_rvalid, o_rdata, o_arb,
                 e_ack, e_we, e_maddr, e_ready, e_cdata, e_rvalid, e_rdata, e_arb);
      end
    end
    idle_visor();
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin
      ram[k]    = 16'(16'h1000 + k);
      shadow[k] = 16'(16'h1000 + k);
    end
    sysreset_n = 0;
    idle_visor();
    model_reset();
    @(negedge sysclk);
    test_reset();
    test_visor_write();
    test_burst_reads();
    test_lock_idle();
    test_lock_writes();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_mem_arbiter.md
Name: code_mem_arbiter

Overview:
Shares the single-port synchronous program memory between the synapse316 instruction fetch port and a supervisor (visor) port used for program download, code patching and code-space peeks. It generates the core's code_ready and code_in from memory grants. It also holds a fixed-latency pipelined request/accept handshake toward the visor. It sits between the core, the code RAM (1-cycle read latency) and the debug supervisor.

Parameters:
CODE_ADDR_WIDTH, 12, width of code addresses; the low bits of the core's code_addr are used.
MAX_VISOR_BURST, 4, maximum consecutive visor grants before one core grant is forced; legal range 1..15.

Ports:
sysclk  in  1  system clock, all state on rising edge
sysreset_n  in  1  asynchronous, active-low reset
core_addr  in  CODE_ADDR_WIDTH  fetch address from core (code_addr)
core_data  out  16  fetched word to core (code_in)
core_ready  out  1  to core code_ready; core_data valid for the previous-cycle core_addr
visor_req  in  1  visor request; addr/we/wdata stable while req=1 and ack=0
visor_we  in  1  1=write, 0=read
visor_addr  in  CODE_ADDR_WIDTH  visor address
visor_wdata  in  16  visor write data
visor_lock  in  1  exclusive visor mode; core never granted
visor_ack  out  1  combinational; request accepted this cycle
visor_rvalid  out  1  read data valid, one cycle after a read ack
visor_rdata  out  16  read data, held until next rvalid
mem_addr  out  CODE_ADDR_WIDTH  to RAM
mem_wdata  out  16  to RAM
mem_we  out  1  to RAM
mem_rdata  in  16  RAM output, valid the cycle after the address
arb_state  out  2  registered grant_q, for debug_out

Behaviour:
- Grant per cycle is combinational:
  - grant_visor = visor_req && (visor_lock || burst_cnt < MAX_VISOR_BURST).
  - grant_core = !grant_visor && !visor_lock.
  - Otherwise idle.
- Memory port muxing:
  - mem_addr = grant_visor ? visor_addr : core_addr.
  - mem_we = grant_visor && visor_we.
  - mem_wdata = visor_wdata always.
- visor_ack = grant_visor. The visor may present a new request in the cycle after ack, so back-to-back accepts are legal.
- grant_q register, encoding G_IDLE=0, G_CORE=1, G_VRD=2, G_VWR=3. It records the grant of the previous cycle; arb_state = grant_q.
- Read return, one cycle after grant:
  - core_ready = (grant_q==G_CORE).
  - core_data = mem_rdata when grant_q==G_CORE, else a hold register holding the last core word.
  - visor_rvalid = (grant_q==G_VRD) registered-equivalent. visor_rdata is captured from mem_rdata in that cycle and held.
  - Writes produce no rvalid.
- burst_cnt (4 bits):
  - +1 on each visor grant.
  - Cleared on any cycle with grant_core, and on any cycle with no visor grant.
  - Not incremented while visor_lock=1; it is cleared when lock is asserted.
  - Saturation guarantees at least one core grant per MAX_VISOR_BURST+1 cycles when unlocked.
- The core holds core_addr whenever core_ready=0. A core grant always completes: a lock asserted after a core grant still yields core_ready=1 the next cycle.
- Simultaneous visor write and core fetch of the same address: visor wins that cycle. The core fetch occurs in a later cycle and observes the new data.
- Reset (async, any cycle): grant_q=G_IDLE, burst_cnt=0, core_ready=0, core_data=0, visor_rvalid=0, visor_rdata=0.
  - In-flight reads are discarded.
  - mem_we is low while reset is asserted.
  - First cycle after release: grant_core when no visor_req; core_ready=1 the cycle after.

Decomposition:
- Shared header: the G_IDLE/G_CORE/G_VRD/G_VWR codes, the CODE_ADDR_WIDTH default (from the system define) and the MAX_VISOR_BURST default.
- No sub-module. The burst counter and grant logic are small enough to stay inline.

Test Plan:
1. Reset release with visor idle; RAM mem[k]=0x1000+k; model core advances core_addr on core_ready -> core_ready=0 in cycle 0 and 1 from cycle 1; core_data sequence 0x1000, 0x1001, 0x1002.
2. Single visor write addr 0x005 data 0xBEEF mid-fetch -> visor_ack and mem_we=1 same cycle, mem_addr=0x005; core_ready=0 next cycle with core_addr held; later core fetch of 0x005 returns 0xBEEF.
3. Continuous visor reads (req held high, MAX_VISOR_BURST=4) -> grant pattern V,V,V,V,C repeating; rvalid 4 of every 5 cycles; core_ready once per 5 cycles; visor_rdata matches mem[addr].
4. visor_lock=1, visor_req=0 for 10 cycles -> core_ready=0, mem_we=0, arb_state=G_IDLE. Lock deasserted -> core_ready=1 exactly one cycle later.
5. visor_lock=1 with 20 back-to-back visor writes -> 20 consecutive acks; no core grant; burst_cnt stays 0.
6. sysreset_n pulsed low the cycle after a visor read ack -> visor_rvalid stays 0, core_ready=0, arb_state=0 immediately (asynchronously). Normal fetch resumes after release.
